// File: rtl/fp_add_align.sv
// fp_add_align -- multi-cycle IEEE-754 single-precision add/subtract front end.
// Captures an operand pair, orders it by magnitude, and aligns the smaller
// significand by one right shift per cycle. It then adds or subtracts the
// 24-bit significands and folds a carry-out into the exponent. The result
// is left un-normalized for the downstream normalizer.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  operand handshake; in_ready is high only while idle
//   in_a, in_b      IEEE single operands
//   in_sub          1: A-B (B sign flipped at capture), 0: A+B
//   out_valid/ready result handshake; outputs held until accepted
//   out_word        {sign, exp[7:0], frac[22:0]}, un-normalized
//   out_hidden      significand bit 23 of the result
//   out_zero        exact zero result
//   out_special     an operand had exp==255; out_word is a passthrough
module fp_add_align #(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_hidden,
  output logic        out_zero,
  output logic        out_special
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_e;

  state_e          state_q, state_d;
  logic            sign_l_q, sign_l_d, sign_s_q, sign_s_d;
  logic [7:0]      exp_l_q, exp_l_d;
  logic [23:0]     sig_l_q, sig_l_d, sig_s_q, sig_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     word_q, word_d;
  logic            hidden_q, hidden_d, zero_q, zero_d, special_q, special_d;

  // ---- capture-side decode ----
  logic [7:0]  exp_a, exp_b, exp_l_c, exp_s_c, diff_c;
  logic [23:0] sig_a, sig_b;
  logic        sgn_b, a_big, spec_a, spec_b;
  logic [CW-1:0] cnt_c;

  always_comb begin
    exp_a  = in_a[30:23];
    exp_b  = in_b[30:23];
    // exp==0 is zero; denormal fractions are flushed
    sig_a  = (exp_a == 8'd0) ? 24'd0 : {1'b1, in_a[22:0]};
    sig_b  = (exp_b == 8'd0) ? 24'd0 : {1'b1, in_b[22:0]};
    sgn_b  = in_b[31] ^ in_sub;
    spec_a = &exp_a;
    spec_b = &exp_b;
    // magnitude order: exponent first, then significand; ties keep A large
    a_big   = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a >= sig_b));
    exp_l_c = a_big ? exp_a : exp_b;
    exp_s_c = a_big ? exp_b : exp_a;
    diff_c  = exp_l_c - exp_s_c;
    cnt_c   = (diff_c > 8'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : CW'(diff_c);
  end

  // ---- result arithmetic (valid once alignment is finished) ----
  logic [24:0] sum;
  logic [7:0]  exp_inc;

  always_comb begin
    // L has the larger magnitude, so the difference never goes negative
    if (sign_l_q == sign_s_q) sum = {1'b0, sig_l_q} + {1'b0, sig_s_q};
    else                      sum = {1'b0, sig_l_q} - {1'b0, sig_s_q};
    exp_inc = exp_l_q + 8'd1;
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (spec_a || spec_b) ? DONE : ALIGN;
      ALIGN:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs decoded from state ----
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_word    = word_q;
  assign out_hidden  = hidden_q;
  assign out_zero    = zero_q;
  assign out_special = special_q;

  // ---- datapath next-state ----
  always_comb begin
    sign_l_d  = sign_l_q;
    sign_s_d  = sign_s_q;
    exp_l_d   = exp_l_q;
    sig_l_d   = sig_l_q;
    sig_s_d   = sig_s_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    hidden_d  = hidden_q;
    zero_d    = zero_q;
    special_d = special_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_l_d = a_big ? in_a[31] : sgn_b;
        sign_s_d = a_big ? sgn_b : in_a[31];
        exp_l_d  = exp_l_c;
        sig_l_d  = a_big ? sig_a : sig_b;
        sig_s_d  = a_big ? sig_b : sig_a;
        cnt_d    = cnt_c;
        if (spec_a || spec_b) begin
          // A wins when both are special; B carries its effective sign
          word_d    = spec_a ? in_a : {sgn_b, in_b[30:0]};
          hidden_d  = 1'b0;
          zero_d    = 1'b0;
          special_d = 1'b1;
        end
      end
      ALIGN: begin
        if (cnt_q != '0) begin
          sig_s_d = sig_s_q >> 1;  // truncating, no sticky
          cnt_d   = cnt_q - CW'(1);
        end else begin
          special_d = 1'b0;
          if (sum == 25'd0) begin
            // -0 only when both effective signs are negative
            word_d   = {sign_l_q & sign_s_q, 31'd0};
            hidden_d = 1'b0;
            zero_d   = 1'b1;
          end else if (sum[24]) begin
            zero_d = 1'b0;
            if (exp_inc == 8'hFF) begin
              word_d   = {sign_l_q, 8'hFF, 23'd0};
              hidden_d = 1'b0;
            end else begin
              word_d   = {sign_l_q, exp_inc, sum[23:1]};
              hidden_d = 1'b1;
            end
          end else begin
            // leading zeros stay for the normalizer; exp untouched
            word_d   = {sign_l_q, exp_l_q, sum[22:0]};
            hidden_d = sum[23];
            zero_d   = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_l_q  <= 1'b0;
      sign_s_q  <= 1'b0;
      exp_l_q   <= '0;
      sig_l_q   <= '0;
      sig_s_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      hidden_q  <= 1'b0;
      zero_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      sign_l_q  <= sign_l_d;
      sign_s_q  <= sign_s_d;
      exp_l_q   <= exp_l_d;
      sig_l_q   <= sig_l_d;
      sig_s_q   <= sig_s_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      hidden_q  <= hidden_d;
      zero_q    <= zero_d;
      special_q <= special_d;
    end
  end

endmodule

// File: tb/tb_fp_add_align.sv
// Directed bench for fp_add_align: a table of operand pairs with
// hand-computed results and latencies, followed by back-pressure and
// mid-operation reset sequences.
// Latency here is the number of rising edges after the accept edge
// before out_valid is seen high (d'+1 for arithmetic, 0 for specials).
module tb_fp_add_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_word;
  logic        out_hidden, out_zero, out_special;

  int total = 0;
  int bad   = 0;

  fp_add_align #(.MAX_SHIFT(25)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_hidden(out_hidden),
    .out_zero(out_zero), .out_special(out_special)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] word;
    logic        hid;
    logic        zr;
    logic        sp;
    int          lat;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // present operands at a falling edge, let the next rising edge accept,
  // then scramble the inputs to show they are ignored after capture
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat;
  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
    out_ready = 1'b1;

    //             a             b             sub   word          hid   zr    sp    lat
    vt[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 1};  // 1+1
    vt[1]  = '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b1, 1'b0, 1'b0, 2};  // 1+0.5
    vt[2]  = '{32'h3F800000, 32'h3F7FFFFE, 1'b1, 32'h3F800001, 1'b0, 1'b0, 1'b0, 2};  // cancellation
    vt[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};  // 1-1
    vt[4]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b1, 1'b0, 1'b0, 25}; // diff 24
    vt[5]  = '{32'h4C800000, 32'h3F800000, 1'b0, 32'h4C800000, 1'b1, 1'b0, 1'b0, 26}; // diff 26, capped
    vt[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0, 1};  // overflow
    vt[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 0};  // NaN A
    vt[8]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 1'b1, 0};  // 1 - inf
    vt[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};  // -0 + -0
    vt[10] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};  // -0 - +0
    vt[11] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};  // +0 + -0
    vt[12] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hC0400000, 1'b0, 1'b0, 1'b0, 2};  // 1-2, swap
    vt[13] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b1, 1'b0, 1'b0, 26}; // denormal flush
    vt[14] = '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 2};  // 3 + -1
    vt[15] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b1, 1'b0, 1'b0, 1};  // 1.5+1.5

    // reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_flags", {29'd0, out_hidden, out_zero, out_special}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].sub);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_word", i), out_word, vt[i].word);
      chk($sformatf("v%0d_hidden", i), {31'd0, out_hidden}, {31'd0, vt[i].hid});
      chk($sformatf("v%0d_zero", i), {31'd0, out_zero}, {31'd0, vt[i].zr});
      chk($sformatf("v%0d_special", i), {31'd0, out_special}, {31'd0, vt[i].sp});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_post_hs_valid", i), {31'd0, out_valid}, 32'd0);
    end

    // back-pressure: result held, no accept while DONE or on the handshake edge
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3F000000, 1'b0);
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd2);
    held = out_word;
    in_valid = 1'b1;
    in_a = 32'h40000000;
    in_b = 32'h40000000;
    in_sub = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_word", k), out_word, 32'h3FC00000);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    chk("bp_word_stable", out_word, held);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_no_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;

    // reset during ALIGN aborts with no output
    issue(32'h4B800000, 32'h3F800000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("align_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_word", out_word, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_no_late_valid", {31'd0, out_valid}, 32'd0);

    // normal operation resumes after the abort
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    wait_valid(lat);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_word", out_word, 32'h40000000);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
